// File: rtl/hd_unload_streamer_if.sv
// ---------------------------------------------------------------------------
// hd_unload_streamer_if
// Output stream of the hard-decision unload streamer.
//
// Handshake: a word transfers on every rising clock edge where out_valid and
// out_ready are both 1. Once out_valid is raised, the master holds out_valid,
// out_word and out_last stable until that transfer happens. out_valid never
// depends on out_ready. out_last marks the final word of a codeword.
//
// Signals
//   out_word   master->slave  HDWIDTH  streamed hard-decision word
//   out_valid  master->slave  1        out_word is valid
//   out_last   master->slave  1        final word of the codeword
//   out_ready  slave->master  1        consumer can accept out_word
// ---------------------------------------------------------------------------
interface hd_unload_streamer_if #(
  parameter int HDWIDTH = 32
) ();
  logic [HDWIDTH-1:0] out_word;
  logic               out_valid;
  logic               out_last;
  logic               out_ready;

  modport master (
    output out_word,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_word,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/hd_unload_streamer.sv
// ---------------------------------------------------------------------------
// hd_unload_streamer
// Reads a decoded codeword from the LLR memory hard-decision unload port
// (rows 0..UNLOAD_ROWS-1) and streams each Kb*HDWIDTH-bit row out as Kb
// words of HDWIDTH bits, word 0 taken from the least significant bits.
//
// Ports
//   clk            clock, all state on posedge
//   rst            asynchronous active-low reset
//   start          one-cycle pulse, begins a codeword (only accepted in IDLE)
//   unload_en      Lmem unload read enable (one cycle per row)
//   unloadAddress  Lmem unload row address
//   hd_vec_in      Lmem registered unload output, RD_LATENCY cycles after read
//   out_if         output stream (master side)
//   busy           high from the cycle after an accepted start until done
//   done           one-cycle pulse after the last word is accepted
//   state_dbg      current FSM state for observation
//
// Per row timing (cycle c = ISSUE):
//   c              unload_en=1, unloadAddress=row
//   c+1..c+RDL     WAIT; hd_vec_in captured into the row buffer at c+RDL
//   c+RDL+1        first word loaded from the buffer into out_word
//   c+RDL+2 ..     STREAM, Kb words
// ---------------------------------------------------------------------------
module hd_unload_streamer #(
  parameter int Kb           = 14,
  parameter int HDWIDTH      = 32,
  parameter int ADDRESSWIDTH = 5,
  parameter int UNLOAD_ROWS  = 17,
  parameter int RD_LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]   hd_vec_in,
  hd_unload_streamer_if.master    out_if,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              state_dbg
);

  localparam int VEC_W  = Kb * HDWIDTH;
  localparam int WORD_W = (Kb > 1) ? $clog2(Kb) : 1;
  localparam int LAT_W  = $clog2(RD_LATENCY + 1) + 1;

  localparam logic [WORD_W-1:0]       WORD_LAST = WORD_W'(Kb - 1);
  localparam logic [ADDRESSWIDTH-1:0] ROW_LAST  = ADDRESSWIDTH'(UNLOAD_ROWS - 1);
  localparam logic [LAT_W-1:0]        LAT_CAP   = LAT_W'(RD_LATENCY - 1);
  localparam logic [LAT_W-1:0]        LAT_LOAD  = LAT_W'(RD_LATENCY);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  logic [2:0]              state_q,     state_d;
  logic [ADDRESSWIDTH-1:0] row_q,       row_d;
  logic [WORD_W-1:0]       word_q,      word_d;
  logic [LAT_W-1:0]        lat_q,       lat_d;
  logic [VEC_W-1:0]        buf_q,       buf_d;
  logic                    unload_en_q, unload_en_d;
  logic [ADDRESSWIDTH-1:0] addr_q,      addr_d;
  logic [HDWIDTH-1:0]      out_word_q,  out_word_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q,  out_last_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;

  logic [WORD_W-1:0]       word_nxt;

  assign word_nxt = word_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    word_d      = word_q;
    lat_d       = lat_q;
    buf_d       = buf_q;
    unload_en_d = 1'b0;
    addr_d      = addr_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ISSUE;
          row_d       = '0;
          addr_d      = '0;
          unload_en_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_ISSUE: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        lat_d = lat_q + 1'b1;
        // Lmem output is valid exactly RD_LATENCY cycles after the read.
        if (lat_q == LAT_CAP) begin
          buf_d = hd_vec_in;
        end
        // One cycle later the buffer is stable: present word 0.
        if (lat_q == LAT_LOAD) begin
          state_d     = ST_STREAM;
          word_d      = '0;
          out_word_d  = buf_q[HDWIDTH-1:0];
          out_valid_d = 1'b1;
          out_last_d  = (row_q == ROW_LAST) && (Kb == 1);
        end
      end

      ST_STREAM: begin
        if (out_if.out_ready) begin
          if (word_q == WORD_LAST) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (row_q == ROW_LAST) begin
              state_d = ST_FIN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d     = ST_ISSUE;
              row_d       = row_q + 1'b1;
              addr_d      = row_q + 1'b1;
              unload_en_d = 1'b1;
            end
          end else begin
            word_d     = word_nxt;
            out_word_d = buf_q[word_nxt*HDWIDTH +: HDWIDTH];
            out_last_d = (row_q == ROW_LAST) && (word_nxt == WORD_LAST);
          end
        end
      end

      ST_FIN: begin
        // A start arriving with done is dropped: only IDLE accepts start.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      word_q      <= '0;
      lat_q       <= '0;
      buf_q       <= '0;
      unload_en_q <= 1'b0;
      addr_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      word_q      <= word_d;
      lat_q       <= lat_d;
      buf_q       <= buf_d;
      unload_en_q <= unload_en_d;
      addr_q      <= addr_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign unload_en        = unload_en_q;
  assign unloadAddress    = addr_q;
  assign out_if.out_word  = out_word_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign state_dbg        = state_q;

endmodule
